hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
- Execute-stage HI/LO unit that consumes the control decoder's alu_op codes: 9 (div/divu), 10 (mult/multu), 12 (mfhi), 13 (mthi), 14 (mflo) and 15 (mtlo).
- Multiply and divide are iterative radix-2 and take multiple cycles; mthi/mtlo writes take one cycle.
- Drives a stall to the pipeline while an operation is in flight, and returns HI/LO on the read path for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op_valid  in  1  EX-stage instruction is valid and not flushed.
- alu_op  in  5  operation code from the control decoder.
- op_unsigned  in  1  funct[0]; 1 selects divu/multu.
- src_a  in  WIDTH  rs value (dividend / multiplicand / mthi-mtlo data).
- src_b  in  WIDTH  rt value (divisor / multiplier).
- hilo_rdata  out  WIDTH  combinational: HI when alu_op==12, LO when alu_op==14, otherwise 0.
- busy  out  1  registered; high while a mult/div is in flight.
- stall  out  1  combinational: busy & op_valid & alu_op in {9,10,12,13,14,15}.
- div_zero  out  1  one-cycle pulse when a divide with src_b==0 completes.

Behaviour:
- Reset (rst_n==0 at an edge) forces:
  - state IDLE, hi=0, lo=0, busy=0, div_zero=0, counter=0.
  - Reset has priority over everything, including an in-flight operation; that operation is abandoned and nothing is written.
- Issue = op_valid & ~stall.
- State IDLE:
  - Issue of op 9 or 10: latch |src_a| and |src_b| (raw values if op_unsigned), latch the result-sign bits, clear the 2*WIDTH accumulator and the counter, then go to DIV or MUL. busy=1 from the next cycle.
  - Issue of op 13: hi <= src_a at that edge. Issue of op 15: lo <= src_a at that edge. Stay in IDLE.
  - Any other alu_op: no state change.
- State MUL:
  - One shift-add step per cycle (multiplier LSB-first); counter increments.
  - When counter==WIDTH-1, go to FIX.
- State DIV:
  - One restoring shift-subtract step per cycle (dividend MSB-first); counter increments.
  - When counter==WIDTH-1, go to FIX.
- State FIX, single cycle, then go to IDLE with busy=0:
  - Apply sign correction and write hi/lo.
  - Signed multiply: negate the 64-bit product if the operand signs differ; {hi,lo} <= product.
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign. lo <= quotient, hi <= remainder.
- Latency:
  - Issue at edge N; busy is high on cycles N+1 through N+33; hi/lo are written at edge N+33.
  - A dependent mfhi/mflo reads the new value in the cycle after N+33.
- Divide by zero: no iterations are skipped; in FIX, lo <= all-ones, hi <= dividend (original src_a), div_zero pulses for that one cycle.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, no flag.
- Absolute value of 0x80000000 is taken as unsigned 0x80000000 (no overflow in the magnitude path).
- Any HI/LO-class op presented while busy is stalled, not dropped. It re-issues the cycle busy falls.
- Ops outside the HI/LO class never stall, even while busy.

Optional Feature:
- Macro HILO_FAST_MUL_EN.
- Defined:
  - mult/multu compute a single-cycle 2*WIDTH product (sign-corrected) and write {hi,lo} at the issue edge.
  - No MUL state; busy is never asserted for multiply.
  - Divide is unchanged.
- Undefined: iterative MUL path as specified above (33-cycle busy).

Test Plan:
- Reset, then mflo with op_valid=1 -> hilo_rdata=0, busy=0, stall=0. Assert rst_n=0 mid-divide -> next cycle busy=0, hi=lo=0.
- mult src_a=0xFFFFFFFE (-2), src_b=7, op_unsigned=0:
  - busy high exactly 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF2.
  - Same operands with multu -> hi=0x00000006, lo=0xFFFFFFF2.
- div src_a=-7 (0xFFFFFFF9), src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100/7 -> lo=14, hi=2.
- div src_a=0x1234, src_b=0 -> div_zero pulses one cycle at completion, lo=0xFFFFFFFF, hi=0x1234. Signed div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue div, then hold mfhi with op_valid=1 the next cycle:
  - stall=1 for 33 cycles, then stall=0 and hilo_rdata equals the new remainder.
  - An add (alu_op=1) presented during busy -> stall=0.
- mthi 0xDEADBEEF then mtlo 0xCAFEF00D on back-to-back cycles -> mfhi reads 0xDEADBEEF, mflo reads 0xCAFEF00D. Repeat the multiply test with HILO_FAST_MUL_EN defined -> busy stays 0 and the result is visible the next cycle.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit for the execute stage.
// Optional single-cycle multiplier selected by HILO_FAST_MUL_EN.
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [4:0]       alu_op,
    input  logic             op_unsigned,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             busy,
    output logic             stall,
    output logic             div_zero
);

    localparam logic [4:0] OP_DIV  = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_MFHI = 5'd12;
    localparam logic [4:0] OP_MTHI = 5'd13;
    localparam logic [4:0] OP_MFLO = 5'd14;
    localparam logic [4:0] OP_MTLO = 5'd15;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef HILO_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`endif

    state_t state, state_nx;

    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg_res, neg_rem, is_div;

    logic               hilo_op, issue, sgn;
    logic [WIDTH-1:0]   a_abs, b_abs;

    assign hilo_op = (alu_op == OP_DIV)  || (alu_op == OP_MUL)  ||
                     (alu_op == OP_MFHI) || (alu_op == OP_MTHI) ||
                     (alu_op == OP_MFLO) || (alu_op == OP_MTLO);
    assign stall = busy & op_valid & hilo_op;
    assign issue = op_valid & ~stall;
    assign sgn   = ~op_unsigned;

    // 0x80000000 maps to itself, read as an unsigned magnitude
    assign a_abs = (sgn & src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_abs = (sgn & src_b[WIDTH-1]) ? -src_b : src_b;

    assign hilo_rdata = (alu_op == OP_MFHI) ? hi :
                        (alu_op == OP_MFLO) ? lo : '0;

    // one multiply step: add multiplicand on multiplier LSB, shift right
    logic [WIDTH:0]     mul_sum;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     (b_mag[0] ? {1'b0, a_mag} : '0);

    // one restoring divide step: shift in next dividend bit, trial subtract
    logic [WIDTH:0]     r_sh, r_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   r_nx;
    assign r_sh   = {acc[2*WIDTH-1:WIDTH], a_mag[WIDTH-1]};
    assign r_diff = r_sh - {1'b0, b_mag};
    assign q_bit  = (r_sh >= {1'b0, b_mag});
    assign r_nx   = q_bit ? r_diff[WIDTH-1:0] : r_sh[WIDTH-1:0];

    // sign correction applied in FIX
    logic [2*WIDTH-1:0] p_fix;
    logic [WIDTH-1:0]   q_fix, rem_fix;
    assign p_fix   = neg_res ? -acc : acc;
    assign q_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH]
                             : acc[2*WIDTH-1:WIDTH];

`ifdef HILO_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
    assign fast_prod = (sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]))
                     ? -fast_mag : fast_mag;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state: iterate WIDTH steps, then one fix-up cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (issue && alu_op == OP_DIV) state_nx = DIV;
`ifndef HILO_FAST_MUL_EN
                else if (issue && alu_op == OP_MUL) state_nx = MUL;
            end
            MUL: begin
                if (cnt == LAST) state_nx = FIX;
`endif
            end
            DIV: begin
                if (cnt == LAST) state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath, HI/LO registers, busy and divide-by-zero flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            a_raw    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        if (alu_op == OP_DIV
`ifndef HILO_FAST_MUL_EN
                            || alu_op == OP_MUL
`endif
                           ) begin
                            a_mag   <= a_abs;
                            b_mag   <= b_abs;
                            a_raw   <= src_a;
                            neg_res <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            neg_rem <= sgn & src_a[WIDTH-1];
                            is_div  <= (alu_op == OP_DIV);
                            acc     <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                        end
`ifdef HILO_FAST_MUL_EN
                        if (alu_op == OP_MUL) {hi, lo} <= fast_prod;
`endif
                        if (alu_op == OP_MTHI) hi <= src_a;
                        if (alu_op == OP_MTLO) lo <= src_a;
                    end
                end
`ifndef HILO_FAST_MUL_EN
                MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    b_mag <= b_mag >> 1;
                    cnt   <= cnt + CNT_W'(1);
                end
`endif
                DIV: begin
                    acc   <= {r_nx, acc[WIDTH-2:0], q_bit};
                    a_mag <= a_mag << 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (is_div) begin
                        if (b_mag == '0) begin
                            lo       <= '1;
                            hi       <= a_raw;
                            div_zero <= 1'b1;
                        end else begin
                            lo <= q_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        {hi, lo} <= p_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
